uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_phy_tx transmitter between N_REQ byte-stream requesters, for example a debug console, a status reporter and a loopback echo.
- Arbitration is round-robin at message granularity. A granted requester keeps the PHY until it sends a byte flagged last, or until its inter-byte timeout expires.
- The block drives the PHY nd/data handshake, honours its rfd, and never issues a byte while the PHY is still holding the previous one.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 1024, cycles the granted requester may stall mid-message, while the PHY is ready, before the grant is revoked; 0 disables
CNT_W, 11, width of the timeout counter; must hold TIMEOUT

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  N_REQ  per-requester byte valid
req_data_i  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last_i  in  N_REQ  byte is the final byte of the message
req_ready_o  out  N_REQ  byte accepted when valid&ready
grant_o  out  N_REQ  one-hot current owner, registered
busy_o  out  1  a grant is active
timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout
phy_rfd_i  in  1  PHY rfd_o
phy_nd_o  out  1  PHY nd_i, registered, one-cycle pulses
phy_data_o  out  8  PHY data_i, registered, valid while phy_nd_o is high

Behaviour:
Reset values (asynchronous, all zero):
- grant_o=0, busy_o=0, timeout_o=0, phy_nd_o=0, phy_data_o=0.
- rr_ptr=0, timeout counter=0, state=ST_IDLE.

States:
- ST_IDLE. The grant is empty. If any req_valid_i is set, select the first set bit scanning from rr_ptr upward with wrap. Register it into grant_o and go to ST_SEND. Otherwise stay.
- ST_SEND.
  - req_ready_o[g] = grant_o[g] & phy_rfd_i & !phy_nd_o; all other ready bits are 0.
  - On valid&ready:
    - Next cycle phy_nd_o=1 and phy_data_o=byte. Latency from accept to nd is 1 cycle.
    - Clear the timeout counter.
  - If the accepted byte has last=1:
    - Clear grant_o next cycle, set rr_ptr=(g+1) mod N_REQ and go to ST_IDLE.
    - Requester g's own next message waits for re-arbitration.
  - If no accept while phy_rfd_i&!phy_nd_o, increment the timeout counter.
    - When the counter reaches TIMEOUT (TIMEOUT>0): clear the grant, pulse timeout_o, set rr_ptr=(g+1) mod N_REQ and go to ST_IDLE.
    - Cycles with the PHY busy do not count.

PHY rule:
- phy_rfd_i depends combinationally on phy_nd_o, so phy_nd_o must come straight from a flop; no combinational path from phy_rfd_i to phy_nd_o.
- The next byte may only be issued after phy_rfd_i is sampled high with phy_nd_o low. This excludes the pulse cycle itself.

Boundary conditions:
- A single-byte message (valid&last in the first accept) occupies ST_SEND for exactly one accept cycle.
- Grant released while others are valid: there is one ST_IDLE cycle, then the new grant. The new owner's first ready cycle is 2 cycles after the last accept, provided phy_rfd_i is high.
- Only the owner requesting: it is re-granted after one ST_IDLE cycle.
- A requester dropping valid mid-message is legal. It is not an error until TIMEOUT.
- Reset mid-message: all state clears immediately. No nd pulse is generated afterwards. The PHY's in-flight byte is the PHY's concern.
- req_last_i is ignored unless valid&ready.

Decomposition:
Package uart_pkg:
- typedef enum logic {ST_IDLE, ST_SEND} arb_state_t
- localparam UART_DATA_W=8

Sub-module rr_arbiter (N_REQ param):
- Inputs: req vector, rr_ptr.
- Output: one-hot pick.
- Purely combinational rotate/priority-encode/rotate-back; instantiated once.

Test Plan:
1. Reset release, req_valid_i=0, phy_rfd_i=1 -> grant_o=0, phy_nd_o=0 and busy_o=0 hold for 20 cycles.
2. Requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), with a real uart_phy_tx and 16x tick -> grant_o=4'b0100 one cycle after valid; exactly 3 nd pulses in order; grant clears the cycle after accepting 0x43; rr_ptr=3.
3. Requesters 0,1,3 all valid with 1-byte messages, rr_ptr=0 -> grant order 0,1,3, then 0 again if still valid; never two grants at once.
4. Granted requester 1 drops valid after 1 byte, TIMEOUT=8 -> timeout_o pulses once after 8 PHY-ready cycles; grant_o=0; requester 3 waiting is granted 2 cycles later.
5. Drive phy_rfd_i with the PHY held in a long frame -> req_ready_o stays 0 until rfd returns; the timeout counter does not advance; no nd while rfd is low.
6. Assert rst_i asynchronously mid-message (between clock edges) -> all outputs 0 before the next edge; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick
);

  logic [2*N_REQ-1:0] dbl_req;
  logic [2*N_REQ-1:0] dbl_pick;
  logic [N_REQ-1:0]   rot_req;
  logic [N_REQ-1:0]   rot_pick;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_req  = {req, req} >> ptr;
    rot_req  = dbl_req[N_REQ-1:0];
    rot_pick = rot_req & (~rot_req + N_REQ'(1));
    dbl_pick = {rot_pick, rot_pick} << ptr;
    pick     = dbl_pick[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of one UART PHY transmitter between
// N_REQ byte-stream requesters, with an inter-byte stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]             req_last_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [N_REQ-1:0]             grant_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  input  logic                         phy_rfd_i,
  output logic                         phy_nd_o,
  output logic [UART_DATA_W-1:0]       phy_data_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t             state_q;
  logic [N_REQ-1:0]       grant_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   nd_q;
  logic [UART_DATA_W-1:0] data_q;
  logic                   timeout_q;

  logic [N_REQ-1:0]       pick;
  logic [N_REQ-1:0]       ready;
  logic [PTR_W-1:0]       g_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [UART_DATA_W-1:0] sel_data;
  logic                   sel_last;
  logic                   phy_ok;
  logic                   accept;
  logic                   timeout_hit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req  (req_valid_i),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Owner byte mux, PHY-ready qualification and accept/timeout detection.
  always_comb begin
    g_idx    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx    = PTR_W'(i);
        sel_data = req_data_i[i*UART_DATA_W +: UART_DATA_W];
        sel_last = req_last_i[i];
      end
    end
    // nd_q comes only from a flop, so rfd never loops back into it.
    phy_ok      = phy_rfd_i & ~nd_q;
    ready       = (state_q == ST_SEND && phy_ok) ? grant_q : '0;
    accept      = |(req_valid_i & ready);
    next_ptr    = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      nd_q      <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      nd_q      <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            grant_q <= pick;
            cnt_q   <= '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            nd_q   <= 1'b1;
            data_q <= sel_data;
            cnt_q  <= '0;
            if (sel_last) begin
              grant_q <= '0;
              ptr_q   <= next_ptr;
              state_q <= ST_IDLE;
            end
          end else if (phy_ok) begin
            // Only stalls with the PHY idle count towards the timeout.
            if (timeout_hit) begin
              grant_q   <= '0;
              timeout_q <= 1'b1;
              ptr_q     <= next_ptr;
              cnt_q     <= '0;
              state_q   <= ST_IDLE;
            end else if (TIMEOUT != 0) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == ST_SEND);
  assign timeout_o   = timeout_q;
  assign phy_nd_o    = nd_q;
  assign phy_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Table-driven cycle-accurate check of uart_tx_arbiter with a bench-driven rfd.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;
  logic           phy_rfd_i;
  logic           phy_nd_o;
  logic [7:0]     phy_data_o;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .phy_rfd_i   (phy_rfd_i),
    .phy_nd_o    (phy_nd_o),
    .phy_data_o  (phy_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         rfd;
    logic [7:0]   base;
    logic [N-1:0] g;
    logic [N-1:0] rdy;
    logic         nd;
    logic [7:0]   d;
    logic         busy;
    logic         to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [N-1:0] v, logic [N-1:0] l, logic rfd,
                              logic [7:0] base, logic [N-1:0] g, logic [N-1:0] rdy,
                              logic nd, logic [7:0] d, logic busy, logic to);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.rfd = rfd; t.base = base;
    t.g = g; t.rdy = rdy; t.nd = nd; t.d = d; t.busy = busy; t.to = to;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  // Requester i sends byte base+i.
  task automatic drive(logic [N-1:0] v, logic [N-1:0] l, logic rfd, logic [7:0] base);
    req_valid_i = v;
    req_last_i  = l;
    phy_rfd_i   = rfd;
    req_data_i  = {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endtask

  task automatic chk_all(int idx, logic [N-1:0] g, logic [N-1:0] rdy, logic nd,
                         logic [7:0] d, logic busy, logic to);
    chk("grant", idx, 32'(grant_o), 32'(g));
    chk("ready", idx, 32'(req_ready_o), 32'(rdy));
    chk("nd", idx, 32'(phy_nd_o), 32'(nd));
    chk("data", idx, 32'(phy_data_o), 32'(d));
    chk("busy", idx, 32'(busy_o), 32'(busy));
    chk("timeout", idx, 32'(timeout_o), 32'(to));
  endtask

  initial begin
    // Single message from requester 2: 0x41, 0x42, 0x43(last).
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h3F, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h3F, 4'b0100, 4'b0100, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h40, 4'b0100, 4'b0000, 1, 8'h41, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 8'h40, 4'b0100, 4'b0100, 0, 8'h41, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h41, 4'b0100, 4'b0000, 1, 8'h42, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h41, 4'b0100, 4'b0100, 0, 8'h42, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 1, 8'h43, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h43, 0, 0));
    // Reset, then 1-byte messages from 0,1,3: order 0,1,3,0.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0001, 4'b0001, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0000, 4'b0000, 1, 8'h10, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0010, 4'b0010, 0, 8'h10, 1, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0000, 4'b0000, 1, 8'h11, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b1000, 4'b1000, 0, 8'h11, 1, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0000, 4'b0000, 1, 8'h13, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 1, 8'h10, 4'b0001, 4'b0001, 0, 8'h13, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 1, 8'h10, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h10, 0, 0));
    // Requester 1 stalls after one byte; two rfd-low cycles do not count.
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 8'h20, 4'b0000, 4'b0000, 0, 8'h10, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b0000, 1, 8'h20, 4'b0010, 4'b0010, 0, 8'h10, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h20, 4'b0010, 4'b0000, 1, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h20, 4'b0010, 4'b0010, 0, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h20, 4'b0010, 4'b0010, 0, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'h20, 4'b0010, 4'b0000, 0, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'h20, 4'b0010, 4'b0000, 0, 8'h21, 1, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h20, 4'b0010, 4'b0010, 0, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 1, 8'h20, 4'b0000, 4'b0000, 0, 8'h21, 0, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 8'h20, 4'b1000, 4'b1000, 0, 8'h21, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 1, 8'h23, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h23, 0, 0));
    // PHY held busy (rfd low) longer than TIMEOUT: no ready, no nd, no revoke.
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 8'h50, 4'b0000, 4'b0000, 0, 8'h23, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 8'h50, 4'b0001, 4'b0000, 0, 8'h23, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 8'h50, 4'b0001, 4'b0001, 0, 8'h23, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 8'h00, 4'b0000, 4'b0000, 1, 8'h50, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h50, 0, 0));
    // Only the owner requesting: re-granted after one idle cycle.
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h3F, 4'b0000, 4'b0000, 0, 8'h50, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h3F, 4'b0100, 4'b0100, 0, 8'h50, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h3F, 4'b0000, 4'b0000, 1, 8'h41, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 8'h3F, 4'b0100, 4'b0100, 0, 8'h41, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 4'b0000, 1, 8'h41, 0, 0));

    rst_i = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 8'h00);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;

    // Idle after reset: nothing granted or sent.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk("idle_grant", c, 32'(grant_o), 32'd0);
      chk("idle_nd", c, 32'(phy_nd_o), 32'd0);
      chk("idle_busy", c, 32'(busy_o), 32'd0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_i = tbl[i].rst;
      drive(tbl[i].v, tbl[i].l, tbl[i].rfd, tbl[i].base);
      #1;
      chk_all(i, tbl[i].g, tbl[i].rdy, tbl[i].nd, tbl[i].d, tbl[i].busy, tbl[i].to);
    end

    // Async reset between edges right after an accept; rr pointer was 3.
    @(negedge clk);
    drive(4'b0100, 4'b0000, 1'b1, 8'h3F);
    @(negedge clk);
    #1;
    chk("ar_grant", 0, 32'(grant_o), 32'(4'b0100));
    @(posedge clk);
    #2;
    chk("ar_nd_pre", 0, 32'(phy_nd_o), 32'd1);
    chk("ar_data_pre", 0, 32'(phy_data_o), 32'h41);
    rst_i = 1'b1;
    #1;
    chk_all(100, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    drive(4'b1010, 4'b0000, 1'b1, 8'h60);
    @(negedge clk);
    #1;
    chk_all(101, 4'b0010, 4'b0010, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b1, 8'h00);
    #1;
    chk_all(102, 4'b0010, 4'b0000, 1'b1, 8'h61, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
